// File: rtl/exec_pipe_pkg.sv
// Shared definitions for exec_pipe: opcode enumeration, FLAGS bit positions,
// default widths and small opcode-class helpers.
package exec_pipe_pkg;

  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned RW_DEF  = 3;
  localparam int unsigned OPW_DEF = 4;

  // FLAGS = {V,C,N,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MOV = 4'd8,
    OP_CMP = 4'd9
  } op_e;

  function automatic logic op_writes(input op_e op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic op_sets_flags(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_pipe: DW-bit modular result, {V,C,N,Z} flags
// and register-write enable for the decoded opcode.
module exec_alu
  import exec_pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  op_e           i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_result,
  output logic [3:0]    o_flags,
  output logic          o_we
);

  localparam int unsigned SHW = $clog2(DW);

  logic [DW:0]    w_sum;
  logic [DW:0]    w_diff;
  logic [SHW-1:0] w_sh;
  logic           w_c;
  logic           w_v;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DW-1:0];
        w_c      = w_sum[DW];
        w_v      = (i_a[DW-1] == i_b[DW-1]) && (w_sum[DW-1] != i_a[DW-1]);
      end
      // C is not-borrow: set when A >= B unsigned
      OP_SUB, OP_CMP: begin
        o_result = w_diff[DW-1:0];
        w_c      = ~w_diff[DW];
        w_v      = (i_a[DW-1] != i_b[DW-1]) && (w_diff[DW-1] != i_a[DW-1]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SHL:  o_result = i_a << w_sh;
      OP_SHR:  o_result = i_a >> w_sh;
      OP_MOV:  o_result = i_a;
      default: o_result = '0;
    endcase
    o_flags         = '0;
    o_flags[FLAG_V] = w_v;
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_N] = o_result[DW-1];
    o_flags[FLAG_Z] = (o_result == '0);
  end

  assign o_we = op_writes(i_op);

endmodule

// File: rtl/exec_pipe.sv
// Three-stage execute pipeline (capture / execute / writeback) in front of an
// external register file. Define EXEC_PIPE_FWD_EN for operand forwarding;
// without it, dependent instructions are held off via IN_READY.
module exec_pipe
  import exec_pipe_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned RW  = RW_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [OPW-1:0] OPCODE,
  input  logic [RW-1:0]  A,
  input  logic [RW-1:0]  B,
  input  logic [RW-1:0]  C,
  input  logic           STALL,
  input  logic           FLUSH,
  output logic [RW-1:0]  A_SEL,
  output logic [RW-1:0]  B_SEL,
  input  logic [DW-1:0]  ADAT,
  input  logic [DW-1:0]  BDAT,
  output logic [RW-1:0]  C_SEL,
  output logic [DW-1:0]  C_OUT,
  output logic           C_WRITE,
  output logic [3:0]     FLAGS
);

`ifdef EXEC_PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic          r_s1_v, r_s1_we;
  op_e           r_s1_op;
  logic [RW-1:0] r_s1_dst, r_s1_asel, r_s1_bsel;
  logic [DW-1:0] r_s1_a, r_s1_b;

  logic          r_s2_v, r_s2_we;
  op_e           r_s2_op;
  logic [RW-1:0] r_s2_dst, r_s2_asel, r_s2_bsel;
  logic [DW-1:0] r_s2_a, r_s2_b;

  logic          r_s3_v, r_s3_we;
  logic [RW-1:0] r_s3_dst;
  logic [DW-1:0] r_s3_res;
  logic [3:0]    r_flags;

  op_e           w_in_op;
  logic          w_in_we, w_accept, w_wr, w_hazard;
  logic [DW-1:0] w_in_a, w_in_b, w_s1_a, w_s1_b, w_s2_a, w_s2_b;
  logic [DW-1:0] w_alu_res;
  logic [3:0]    w_alu_flags;
  logic          w_alu_we;

  assign w_in_op  = (OPCODE <= OPW'(OP_CMP)) ? op_e'(OPCODE[3:0]) : OP_NOP;
  assign w_in_we  = op_writes(w_in_op);
  assign w_wr     = r_s3_v & r_s3_we & ~STALL;
  assign w_accept = IN_VALID & IN_READY;

  // A register written on an edge is picked up from C_OUT by whichever of
  // S1-capture or S1->S2 happens on that same edge; the S2 mux covers the
  // producer sitting directly ahead in S3.
  assign w_in_a = (FWD_EN && w_wr && r_s3_dst == A) ? r_s3_res : ADAT;
  assign w_in_b = (FWD_EN && w_wr && r_s3_dst == B) ? r_s3_res : BDAT;
  assign w_s1_a = (FWD_EN && w_wr && r_s3_dst == r_s1_asel) ? r_s3_res : r_s1_a;
  assign w_s1_b = (FWD_EN && w_wr && r_s3_dst == r_s1_bsel) ? r_s3_res : r_s1_b;
  assign w_s2_a = (FWD_EN && r_s3_v && r_s3_we && r_s3_dst == r_s2_asel) ? r_s3_res : r_s2_a;
  assign w_s2_b = (FWD_EN && r_s3_v && r_s3_we && r_s3_dst == r_s2_bsel) ? r_s3_res : r_s2_b;

  assign w_hazard = IN_VALID && (
      (r_s1_v && r_s1_we && (r_s1_dst == A || r_s1_dst == B)) ||
      (r_s2_v && r_s2_we && (r_s2_dst == A || r_s2_dst == B)) ||
      (r_s3_v && r_s3_we && (r_s3_dst == A || r_s3_dst == B)));

  assign IN_READY = ~RST & ~STALL & (FWD_EN | ~w_hazard);

  exec_alu #(.DW(DW)) u_alu (
    .i_op     (r_s2_op),
    .i_a      (w_s2_a),
    .i_b      (w_s2_b),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags),
    .o_we     (w_alu_we)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s3_v   <= 1'b0;
      r_s3_we  <= 1'b0;
      r_s3_dst <= '0;
      r_s3_res <= '0;
      r_flags  <= '0;
    end else if (!STALL) begin
      if (FLUSH) begin
        r_s1_v <= 1'b0;
        r_s2_v <= 1'b0;
        r_s3_v <= 1'b0;
      end else begin
        r_s1_v <= w_accept;
        r_s2_v <= r_s1_v;
        r_s3_v <= r_s2_v;
        if (r_s2_v) begin
          r_s3_we  <= w_alu_we;
          r_s3_dst <= r_s2_dst;
          r_s3_res <= w_alu_res;
          if (op_sets_flags(r_s2_op)) r_flags <= w_alu_flags;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!STALL) begin
      if (w_accept) begin
        r_s1_op   <= w_in_op;
        r_s1_we   <= w_in_we;
        r_s1_dst  <= C;
        r_s1_asel <= A;
        r_s1_bsel <= B;
        r_s1_a    <= w_in_a;
        r_s1_b    <= w_in_b;
      end
      if (r_s1_v) begin
        r_s2_op   <= r_s1_op;
        r_s2_we   <= r_s1_we;
        r_s2_dst  <= r_s1_dst;
        r_s2_asel <= r_s1_asel;
        r_s2_bsel <= r_s1_bsel;
        r_s2_a    <= w_s1_a;
        r_s2_b    <= w_s1_b;
      end
    end
  end

  assign A_SEL   = A;
  assign B_SEL   = B;
  assign C_SEL   = r_s3_dst;
  assign C_OUT   = r_s3_res;
  assign C_WRITE = w_wr;
  assign FLAGS   = r_flags;

endmodule

// File: tb/tb_exec_pipe.sv
// Directed self-checking bench for exec_pipe with a behavioural register file.
// Dependency tests follow EXEC_PIPE_FWD_EN (bypass vs. IN_READY hold-off).
`timescale 1ns/1ps
module tb_exec_pipe;
  import exec_pipe_pkg::*;

  localparam int unsigned DW = 16, RW = 3, OPW = 4;

  logic           CLK = 1'b0, RST = 1'b1;
  logic           IN_VALID = 1'b0, STALL = 1'b0, FLUSH = 1'b0;
  logic           IN_READY, C_WRITE;
  logic [OPW-1:0] OPCODE = '0;
  logic [RW-1:0]  A = '0, B = '0, C = '0;
  logic [RW-1:0]  A_SEL, B_SEL, C_SEL;
  logic [DW-1:0]  ADAT, BDAT, C_OUT;
  logic [3:0]     FLAGS;

  exec_pipe #(.DW(DW), .RW(RW), .OPW(OPW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .A(A), .B(B), .C(C), .STALL(STALL), .FLUSH(FLUSH),
    .A_SEL(A_SEL), .B_SEL(B_SEL), .ADAT(ADAT), .BDAT(BDAT),
    .C_SEL(C_SEL), .C_OUT(C_OUT), .C_WRITE(C_WRITE), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned   cyc;
    logic [RW-1:0] sel;
    logic [DW-1:0] dat;
  } wr_t;

  wr_t           wlog[$];
  logic [DW-1:0] rf[8];
  logic [DW-1:0] rf_init[8];
  logic          rf_load = 1'b0;
  int unsigned   cyc = 0;
  int unsigned   n_checks = 0, n_fail = 0;

  assign ADAT = rf[A_SEL];
  assign BDAT = rf[B_SEL];

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (C_WRITE) begin
      rf[C_SEL] <= C_OUT;
      wlog.push_back('{cyc, C_SEL, C_OUT});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int unsigned idx,
                        input logic [RW-1:0] sel, input logic [DW-1:0] dat);
    if (int'(idx) < wlog.size()) begin
      chk({tag, "_sel"}, 32'(wlog[idx].sel), 32'(sel));
      chk({tag, "_dat"}, 32'(wlog[idx].dat), 32'(dat));
    end else begin
      chk({tag, "_present"}, 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  task automatic preload(input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                         input logic [DW-1:0] v3, input logic [DW-1:0] v5);
    for (int i = 0; i < 8; i++) rf_init[i] = '0;
    rf_init[1] = v1;
    rf_init[2] = v2;
    rf_init[3] = v3;
    rf_init[5] = v5;
    rf_load = 1'b1;
    @(negedge CLK);
    rf_load = 1'b0;
  endtask

  // Offers one instruction, waits (bounded) for IN_READY, returns after the
  // accepting edge with the number of refused cycles and the accept cycle.
  task automatic issue(input op_e op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [RW-1:0] c, output int unsigned waits,
                       output int unsigned acc);
    OPCODE = op; A = a; B = b; C = c; IN_VALID = 1'b1;
    waits = 0;
    #1;
    while (!IN_READY && waits < 20) begin
      @(negedge CLK); #1;
      waits++;
    end
    if (!IN_READY) chk("issue_ready", 32'(IN_READY), 32'd1);
    @(negedge CLK);
    acc = cyc;
    IN_VALID = 1'b0;
  endtask

  int unsigned w0, w1, a0, a1, a2, base, base2;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish within 100000ns");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_cwrite", 32'(C_WRITE), 32'd0);
    chk("rst_cout",   32'(C_OUT),   32'd0);
    chk("rst_csel",   32'(C_SEL),   32'd0);
    chk("rst_flags",  32'(FLAGS),   32'd0);
    chk("rst_ready",  32'(IN_READY), 32'd0);
    RST = 1'b0;
    #1;
    chk("idle_ready", 32'(IN_READY), 32'd1);

    // ADD r3=r1+r2 then SUB r4=r3-r1
    preload(16'd5, 16'd3, 16'd0, 16'd0);
    base = wlog.size();
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, w0, a0);
    issue(OP_SUB, 3'd3, 3'd1, 3'd4, w1, a1);
    repeat (8) @(negedge CLK);
    chk("dep_nwr", 32'(wlog.size() - base), 32'd2);
    chk_wr("dep_add", base, 3'd3, 16'd8);
    chk_wr("dep_sub", base + 1, 3'd4, 16'd3);
    if (wlog.size() >= base + 2) begin
      chk("dep_add_lat", wlog[base].cyc - a0, 32'd3);
      chk("dep_sub_lat", wlog[base + 1].cyc - a1, 32'd3);
    end
`ifdef EXEC_PIPE_FWD_EN
    chk("dep_waits", w1, 32'd0);
    chk("dep_accept_gap", a1 - a0, 32'd1);

    // ADD r3, NOP, MOV r5=r3 with a stale r3 in the register file
    preload(16'd5, 16'd3, 16'hDEAD, 16'd0);
    base = wlog.size();
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, w0, a0);
    issue(OP_NOP, 3'd0, 3'd0, 3'd0, w0, a1);
    issue(OP_MOV, 3'd3, 3'd0, 3'd5, w1, a2);
    repeat (8) @(negedge CLK);
    chk("byp2_nwr", 32'(wlog.size() - base), 32'd2);
    chk_wr("byp2_mov", base + 1, 3'd5, 16'd8);
    if (wlog.size() >= base + 2) chk("byp2_lat", wlog[base + 1].cyc - a2, 32'd3);
`else
    chk("dep_waits", w1, 32'd3);
`endif

    // flag behaviour
    preload(16'hFFFF, 16'h0001, 16'd0, 16'h7FFF);
    base = wlog.size();
    issue(OP_ADD, 3'd1, 3'd2, 3'd3, w0, a0);
    repeat (4) @(negedge CLK);
    chk_wr("flg_add", base, 3'd3, 16'h0000);
    chk("flg_add_flags", 32'(FLAGS), 32'h5);
    issue(OP_AND, 3'd1, 3'd2, 3'd4, w0, a0);
    repeat (4) @(negedge CLK);
    chk_wr("flg_and", base + 1, 3'd4, 16'h0001);
    chk("flg_and_flags", 32'(FLAGS), 32'h5);
    issue(OP_CMP, 3'd5, 3'd1, 3'd6, w0, a0);
    repeat (4) @(negedge CLK);
    chk("flg_cmp_nwr", 32'(wlog.size() - base), 32'd2);
    chk("flg_cmp_flags", 32'(FLAGS), 32'hA);

    // stall with XOR in S3 and OR in S2
    preload(16'd5, 16'd3, 16'd0, 16'd0);
    base = wlog.size();
    issue(OP_XOR, 3'd1, 3'd2, 3'd6, w0, a0);
    issue(OP_OR,  3'd1, 3'd2, 3'd7, w0, a1);
    @(negedge CLK); #1;
    chk("stall_pre_cwrite", 32'(C_WRITE), 32'd1);
    STALL = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_cwrite", 32'(C_WRITE), 32'd0);
      chk("stall_ready",  32'(IN_READY), 32'd0);
      @(negedge CLK); #1;
    end
    STALL = 1'b0;
    #1;
    chk("stall_rel_cwrite", 32'(C_WRITE), 32'd1);
    chk("stall_rel_csel",   32'(C_SEL),   32'd6);
    chk("stall_rel_cout",   32'(C_OUT),   32'd6);
    repeat (4) @(negedge CLK);
    chk("stall_nwr", 32'(wlog.size() - base), 32'd2);
    chk_wr("stall_xor", base, 3'd6, 16'd6);
    chk_wr("stall_or", base + 1, 3'd7, 16'd7);
    if (wlog.size() >= base + 1) chk("stall_lat", wlog[base].cyc - a0, 32'd6);

    // flush with three in flight and a fresh offer on the flush edge
    preload(16'd5, 16'd3, 16'd0, 16'd0);
    issue(OP_OR,  3'd1, 3'd2, 3'd5, w0, a0);
    issue(OP_AND, 3'd1, 3'd2, 3'd6, w0, a0);
    issue(OP_XOR, 3'd1, 3'd2, 3'd7, w0, a0);
    FLUSH = 1'b1;
    OPCODE = OP_MOV; A = 3'd1; B = 3'd0; C = 3'd4; IN_VALID = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    base2 = wlog.size();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_cwrite", 32'(C_WRITE), 32'd0);
      @(negedge CLK); #1;
    end
    chk("flush_nwr", 32'(wlog.size() - base2), 32'd0);

    // reset in the middle of a stream
    preload(16'd5, 16'd3, 16'd0, 16'd0);
    issue(OP_SUB, 3'd2, 3'd1, 3'd3, w0, a0);
    issue(OP_OR,  3'd1, 3'd2, 3'd5, w0, a0);
    issue(OP_AND, 3'd1, 3'd2, 3'd6, w0, a0);
    #1;
    chk("prerst_flags",  32'(FLAGS),   32'h2);
    chk("prerst_cout",   32'(C_OUT),   32'hFFFE);
    chk("prerst_cwrite", 32'(C_WRITE), 32'd1);
    #1;
    RST = 1'b1;
    base = wlog.size();
    #1;
    chk("midrst_cwrite", 32'(C_WRITE),  32'd0);
    chk("midrst_cout",   32'(C_OUT),    32'd0);
    chk("midrst_csel",   32'(C_SEL),    32'd0);
    chk("midrst_flags",  32'(FLAGS),    32'd0);
    chk("midrst_ready",  32'(IN_READY), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midrst_nwr", 32'(wlog.size() - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_pipe.md
EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 SHALL have parameter DW, default 16, meaning operand/result data width (>=8).
REQ-002 SHALL have parameter RW, default 3, meaning register-address width (2**RW registers).
REQ-003 SHALL have parameter OPW, default 4, meaning opcode width (>=4).
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port IN_VALID  input  1  the instruction on OPCODE/A/B/C is offered.
REQ-007 SHALL have port IN_READY  output  1  the instruction is accepted on this edge when IN_VALID is also high.
REQ-008 SHALL have ports OPCODE input OPW, A input RW, B input RW, C input RW: the opcode, source A, source B and destination register.
REQ-009 SHALL have port STALL  input  1  freezes every stage.
REQ-010 SHALL have port FLUSH  input  1  discards all in-flight instructions.
REQ-011 SHALL have ports A_SEL output RW and B_SEL output RW: register-file read addresses, combinationally equal to A and B.
REQ-012 SHALL have ports ADAT input DW and BDAT input DW: register-file read data for A_SEL and B_SEL, valid in the same cycle.
REQ-013 SHALL have ports C_SEL output RW, C_OUT output DW and C_WRITE output 1: the register-file write port.
REQ-014 SHALL have port FLAGS  output  4  {V,C,N,Z} of the last flag-setting instruction.

Function
REQ-015 SHALL implement three stages: S1 operand capture, S2 execute, S3 writeback register; each stage has a valid bit.
REQ-016 SHALL assert IN_READY = ~STALL (forwarding build); an instruction is accepted when IN_VALID & IN_READY.
REQ-017 SHALL give a result-to-C_WRITE latency of 3 edges after acceptance, with one instruction per cycle throughput.
REQ-018 SHALL implement these opcodes: 0 NOP, 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 SHL (A<<B[log2 DW-1:0]), 7 SHR logical, 8 MOV (A), and 9 CMP (SUB that sets flags only); opcodes 10 and above SHALL execute as NOP.
REQ-019 SHALL perform DW-bit modular arithmetic; C is the carry out of ADD and the not-borrow of SUB/CMP, V is two's-complement overflow, and Z/N are derived from the DW-bit result.
REQ-020 SHALL update FLAGS only when an ADD, SUB or CMP instruction enters S3; no other opcode changes FLAGS.
REQ-021 SHALL set write-enable for opcodes 1-8 only.
REQ-022 SHALL drive C_WRITE = S3.valid & S3.we & ~STALL.
REQ-023 SHALL take an S2 operand from C_OUT when S3 is valid, S3.we is set and S3.dest equals that source.
REQ-024 SHALL capture C_OUT instead of ADAT/BDAT in S1 when the same-edge write matches A or B.
REQ-025 SHALL hold all stage registers while STALL is high; STALL takes priority over FLUSH.
REQ-026 SHALL, on FLUSH without STALL, clear all valid bits and accept no instruction on that edge.
REQ-027 SHALL make a stage that is not valid produce no write and no flag update.

Reset
REQ-028 SHALL clear all valid bits, C_OUT, C_SEL, FLAGS and C_WRITE to 0 asynchronously on RST high.
REQ-029 SHALL discard in-flight instructions on reset mid-operation, so that no write occurs on or after the reset edge.
REQ-030 SHALL drive IN_READY to 0 while RST is high.

Configuration
REQ-031 SHALL, when EXEC_PIPE_FWD_EN is defined, implement REQ-023/REQ-024 forwarding.
REQ-032 SHALL, when EXEC_PIPE_FWD_EN is undefined, omit forwarding and drive IN_READY = ~STALL & ~hazard, where hazard means A or B of a valid offered instruction matches the dest of any valid S1/S2/S3 instruction with we set.

Structure
REQ-033 SHALL place the opcode enumeration, the flag bit indices and the default DW/RW/OPW in package exec_pipe_pkg.
REQ-034 SHALL place combinational ALU logic in sub-module exec_alu (op, a, b -> result, flags, we).

Verification
REQ-035 SHALL verify back-to-back dependency: r1=5 and r2=3 in the regfile; issue ADD r3=r1+r2, then SUB r4=r3-r1 on the next cycle -> C_WRITE r3=8, then r4=3 one cycle later, with no bubble (FWD_EN).
REQ-036 SHALL verify distance-2 bypass: ADD r3=r1+r2, NOP, then MOV r5=r3 -> C_OUT=8 written to r5 (FWD_EN).
REQ-037 SHALL verify flags: ADD of 0xFFFF+0x0001 -> C_OUT=0 and FLAGS Z=1,C=1; a subsequent AND leaves FLAGS unchanged; CMP 0x7FFF-0xFFFF -> V=1,N=1.
REQ-038 SHALL verify stall: STALL high for 3 cycles with S3 valid -> C_WRITE=0 throughout and the same C_OUT/C_SEL presented after release, with exactly one write.
REQ-039 SHALL verify flush and reset: FLUSH with 3 valid instructions in flight -> no C_WRITE for the next 3 cycles; RST asserted mid-stream -> all outputs 0 immediately.
REQ-040 SHALL verify the build without forwarding: issue the REQ-035 sequence -> IN_READY low for 3 cycles, and r4=3 is still correct.
